// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: binary state encoding
// ({active, grant index}) and a width helper for ptr/cnt.
package arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'h0,
    ST_GRANT_0 = 4'h8,
    ST_GRANT_1 = 4'h9,
    ST_GRANT_2 = 4'hA,
    ST_GRANT_3 = 4'hB,
    ST_GRANT_4 = 4'hC,
    ST_GRANT_5 = 4'hD,
    ST_GRANT_6 = 4'hE,
    ST_GRANT_7 = 4'hF
  } state_t;

  // Width needed to hold 0..v-1, never less than one bit.
  function automatic int clog2w(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

  function automatic state_t grant_state(input logic [2:0] idx);
    return state_t'({1'b1, idx});
  endfunction

  function automatic logic is_grant(input state_t s);
    return s[3];
  endfunction

  function automatic logic [2:0] grant_idx(input state_t s);
    return s[2:0];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first asserted req bit scanning
// ptr+1, ptr+2, ... mod N, optionally skipping one excluded index.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          excl_en,
  input  logic [PW-1:0] excl,
  output logic          found,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] j;

  // Walk from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = N; i >= 1; i--) begin
      j = PW'((int'(ptr) + i) % N);
      if (req[j] && !(excl_en && (j == excl))) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// Moore round-robin arbiter: IDLE plus one grant state per requester, with
// priority rotation and forced release of a holder that overstays under contention.
module rr_arbiter_fsm
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] r,
  output logic [N-1:0] g,
  output logic         busy,
  output logic         timeout
);

  localparam int PW = clog2w(N);
  localparam int CW = clog2w(MAX_HOLD);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  g_d;
  logic          timeout_d;
  logic          take;

  logic          active;
  logic [PW-1:0] hold_idx;
  logic          found;
  logic [PW-1:0] pick_idx;

  assign active   = is_grant(state_q);
  assign hold_idx = PW'(grant_idx(state_q));

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req     (r),
    .ptr     (ptr_q),
    .excl_en (active),
    .excl    (hold_idx),
    .found   (found),
    .idx     (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    take      = 1'b0;
    g_d       = '0;

    if (!active) begin
      cnt_d = '0;
      take  = found;
    end else if (!r[hold_idx]) begin
      // Voluntary release hands straight over when someone else is waiting.
      if (found) begin
        take = 1'b1;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if ((cnt_q == CNT_MAX) && found) begin
      take      = 1'b1;
      timeout_d = 1'b1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (take) begin
      state_d = grant_state(3'(pick_idx));
      ptr_d   = pick_idx;
      cnt_d   = '0;
    end

    for (int i = 0; i < N; i++) begin
      g_d[i] = is_grant(state_d) && (grant_idx(state_d) == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(N - 1);
      cnt_q   <= '0;
      g       <= '0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      g       <= g_d;
      timeout <= timeout_d;
    end
  end

  assign busy = |g;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Self-checking bench for rr_arbiter_fsm (N=4, MAX_HOLD=4): directed scenarios
// plus randomized traffic against a behavioural round-robin model.
module tb_rr_arbiter_fsm;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] r;
  logic [N-1:0] g;
  logic         busy;
  logic         timeout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: holder = -1 means nobody owns the resource.
  int           m_holder;
  int           m_ptr;
  int           m_cnt;
  logic         m_to;
  logic [N-1:0] m_g;

  rr_arbiter_fsm #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .r       (r),
    .g       (g),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic model_update(input logic [N-1:0] rv, input logic rs);
    int pick;
    pick = -1;
    m_to = 1'b0;
    if (rs) begin
      m_holder = -1;
      m_ptr    = N - 1;
      m_cnt    = 0;
    end else begin
      for (int off = N; off >= 1; off--) begin
        int k;
        k = (m_ptr + off) % N;
        if (rv[k] && k != m_holder) pick = k;
      end
      if (m_holder < 0 || !rv[m_holder]) begin
        if (pick >= 0) begin
          m_holder = pick; m_ptr = pick; m_cnt = 0;
        end else begin
          m_holder = -1; m_cnt = 0;
        end
      end else if (m_cnt == MAX_HOLD - 1 && pick >= 0) begin
        m_holder = pick; m_ptr = pick; m_cnt = 0; m_to = 1'b1;
      end else if (m_cnt < MAX_HOLD - 1) begin
        m_cnt = m_cnt + 1;
      end
    end
    m_g = '0;
    if (m_holder >= 0) m_g[m_holder] = 1'b1;
  endtask

  task automatic step(input logic [N-1:0] rv, input logic rs);
    r     = rv;
    reset = rs;
    @(posedge clk);
    model_update(rv, rs);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(4'b1111, 1'b1);
      total_cnt++;
      if (g !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0)
        $display("FAIL reset_hold c%0d: g=%b busy=%b timeout=%b, want g=0000 busy=0 timeout=0", c, g, busy, timeout);
      else pass_cnt++;
    end
    step(4'b1111, 1'b0);
    total_cnt++;
    if (g !== 4'b0001 || busy !== 1'b1)
      $display("FAIL reset_first_grant: g=%b busy=%b, want g=0001 busy=1", g, busy);
    else pass_cnt++;
  endtask

  task automatic test_single();
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    total_cnt++;
    if (g !== 4'b0100 || timeout !== 1'b0)
      $display("FAIL single_grant: g=%b timeout=%b, want g=0100 timeout=0", g, timeout);
    else pass_cnt++;
    step(4'b0000, 1'b0);
    total_cnt++;
    if (g !== 4'b0000 || busy !== 1'b0)
      $display("FAIL single_release: g=%b busy=%b, want g=0000 busy=0", g, busy);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_g;
    logic         exp_to;
    step(4'b0000, 1'b1);
    for (int c = 0; c < 17; c++) begin
      step(4'b1111, 1'b0);
      exp_g  = 4'b0001 << ((c / MAX_HOLD) % N);
      exp_to = (c > 0) && (c % MAX_HOLD == 0);
      total_cnt++;
      if (g !== exp_g || timeout !== exp_to)
        $display("FAIL contention c%0d: g=%b timeout=%b, want g=%b timeout=%b", c, g, timeout, exp_g, exp_to);
      else pass_cnt++;
    end
  endtask

  task automatic test_handoff();
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b0);
    total_cnt++;
    if (g !== 4'b0001)
      $display("FAIL handoff_start: g=%b, want 0001", g);
    else pass_cnt++;
    step(4'b1010, 1'b0);
    total_cnt++;
    if (g !== 4'b0010 || timeout !== 1'b0)
      $display("FAIL handoff_next: g=%b timeout=%b, want g=0010 timeout=0", g, timeout);
    else pass_cnt++;
    step(4'b1000, 1'b0);
    total_cnt++;
    if (g !== 4'b1000 || timeout !== 1'b0)
      $display("FAIL handoff_last: g=%b timeout=%b, want g=1000 timeout=0", g, timeout);
    else pass_cnt++;
  endtask

  task automatic test_lone_holder();
    step(4'b0000, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step(4'b0010, 1'b0);
      total_cnt++;
      if (g !== 4'b0010 || timeout !== 1'b0)
        $display("FAIL lone_hold c%0d: g=%b timeout=%b, want g=0010 timeout=0", c, g, timeout);
      else pass_cnt++;
    end
    step(4'b0011, 1'b0);
    total_cnt++;
    if (g !== 4'b0001 || timeout !== 1'b1)
      $display("FAIL lone_preempt: g=%b timeout=%b, want g=0001 timeout=1", g, timeout);
    else pass_cnt++;
    step(4'b0011, 1'b0);
    total_cnt++;
    if (timeout !== 1'b0)
      $display("FAIL lone_pulse_width: timeout=%b, want 0", timeout);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_grant();
    step(4'b0000, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b0100, 1'b0);
    total_cnt++;
    if (g !== 4'b0100)
      $display("FAIL midreset_setup: g=%b, want 0100", g);
    else pass_cnt++;
    step(4'b1111, 1'b1);
    total_cnt++;
    if (g !== 4'b0000 || timeout !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_clear: g=%b timeout=%b busy=%b, want all zero", g, timeout, busy);
    else pass_cnt++;
    for (int c = 0; c < MAX_HOLD; c++) begin
      step(4'b1111, 1'b0);
      total_cnt++;
      if (g !== 4'b0001 || timeout !== 1'b0)
        $display("FAIL midreset_regrant c%0d: g=%b timeout=%b, want g=0001 timeout=0", c, g, timeout);
      else pass_cnt++;
    end
    step(4'b1111, 1'b0);
    total_cnt++;
    if (g !== 4'b0010 || timeout !== 1'b1)
      $display("FAIL midreset_rotate: g=%b timeout=%b, want g=0010 timeout=1", g, timeout);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [N-1:0] rv;
    logic         rs;
    rv = '0;
    step(4'b0000, 1'b1);
    for (int c = 0; c < 400; c++) begin
      // Requests are sticky so holders often reach the preemption limit.
      if ($urandom_range(0, 3) == 0) rv = N'($urandom_range(0, 15));
      rs = ($urandom_range(0, 59) == 0);
      step(rv, rs);
      total_cnt++;
      if (g !== m_g || timeout !== m_to || busy !== (|m_g))
        $display("FAIL random c%0d r=%b rst=%b: g=%b timeout=%b busy=%b, want g=%b timeout=%b busy=%b",
                 c, rv, rs, g, timeout, busy, m_g, m_to, |m_g);
      else pass_cnt++;
    end
  endtask

  initial begin
    r        = '0;
    reset    = 1'b1;
    m_holder = -1;
    m_ptr    = N - 1;
    m_cnt    = 0;
    m_to     = 1'b0;
    m_g      = '0;
    #1;
    test_reset();
    test_single();
    test_contention();
    test_handoff();
    test_lone_holder();
    test_reset_mid_grant();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_fsm.md
# rr_arbiter_fsm

Round-robin arbiter that shares one single-owner resource among N requesters. It is a Moore state machine: an idle state plus one grant state per requester. It rotates priority after every grant and force-releases a holder that keeps the grant past a programmable limit while others wait. It sits between requester FSMs and the shared resource's enable/select logic.

## Interface
- N, default 4, number of requesters (2..8)
- MAX_HOLD, default 8, maximum consecutive grant cycles while another request is pending (≥2)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, sampled on clk rising edge
- r  input  N  request vector, level-sensitive, bit k = requester k
- g  output  N  grant vector, one-hot or zero, registered (Moore, decoded from state)
- busy  output  1  |g
- timeout  output  1  one-cycle pulse marking a forced preemption

## Operation
- States: IDLE, GRANT_0..GRANT_{N-1}. Internal: ptr (last granted index), cnt (cycles in current grant).
- Reset values: state=IDLE, g=0, busy=0, timeout=0, ptr=N-1, cnt=0. Requester 0 therefore wins first after reset.
- Pick function: first asserted bit of r, scanning ptr+1, ptr+2, … mod N, with the current holder excluded.
- IDLE:
  - r=0 → stay.
  - Otherwise → GRANT_pick.
- GRANT_k, r[k]=0 (release):
  - If another request is pending → GRANT_pick directly, no idle bubble.
  - Else → IDLE.
- GRANT_k, r[k]=1, cnt==MAX_HOLD-1, another request pending → GRANT_pick (preempt); timeout=1 in the first cycle of the new grant.
- GRANT_k, r[k]=1, otherwise → stay.
  - cnt increments and saturates at MAX_HOLD-1.
  - A lone holder keeps the grant indefinitely. It is preempted on the first edge where another request is seen with cnt saturated.
- On entering any GRANT_j: ptr←j, cnt←0.
- timeout is 0 on every cycle except the first cycle after a preemption.
- cnt width: clog2(MAX_HOLD). ptr width: clog2(N). Index arithmetic wraps mod N.

## Timing
- Request-to-grant latency: 1 edge. r sampled at edge e gives g valid after edge e.
- Release-to-regrant latency: 1 edge, with no cycle where g=0 when another request is pending.
- Grant length under contention: exactly MAX_HOLD cycles unless released earlier.
- g never changes except on a clk rising edge; g is never multi-hot.
- Reset asserted mid-grant: at the next edge g=0, timeout=0, ptr=N-1, cnt=0, regardless of r.
- Reset and r both asserted: reset wins. The first grant appears one edge after reset deasserts.

## Structure
- Shared package arb_pkg holds:
  - the state encoding (IDLE plus grant index, binary-encoded)
  - a helper function for the clog2 widths
- One sub-module, rr_pick: purely combinational rotating priority encoder.
  - Inputs: req[N], ptr, exclude index.
  - Outputs: found, idx.
- The arbiter holds all state, cnt, ptr and output registers.

## Test plan
All scenarios use N=4, MAX_HOLD=4.
1. Reset: reset=1 for 2 cycles with r=4'b1111 → g=0, busy=0, timeout=0 throughout; first edge after deassert → g=4'b0001.
2. Single request: r=4'b0100 at edge e → g=4'b0100 after e. Drop r → g=0, busy=0 after the next edge.
3. Full contention: r=4'b1111 held → g=0001×4, 0010×4, 0100×4, 1000×4, then 0001 again. timeout=1 on the first cycle of each new grant after the first.
4. Handoff: while g=0001, r goes 0001→1010 → next g=0010 (ptr=0 scans 1 first) with no zero cycle and timeout=0. Then r=1000 → g=1000.
5. Lone holder: r=0010 for 10 cycles → g=0010 throughout, timeout=0. r=0011 on cycle 11 → g=0001 next edge, timeout=1.
6. Reset mid-grant: during g=0100 with cnt=2, pulse reset=1 for one cycle with r=1111 → g=0 after that edge. After deassert → g=0001, cnt restarts, and the next grant lasts the full 4 cycles.
